// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser serial-to-parallel deserializer.
package sipo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH + 1);
  // Widest word the parity helper covers; narrower words are zero-extended.
  localparam int unsigned PAR_MAX_W = 64;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

  // Even parity of a data word; zero-extension leaves the result unchanged.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input, word output and handshake bundle for sipo_deser.
interface sipo_deser_if #(
  parameter int unsigned WIDTH = 8
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             si;
  logic             si_valid;
  logic             clr;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             overrun;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_err;

  modport master (
    output si, si_valid, clr, po_ready,
    input  po, po_valid, overrun, bit_cnt, par_err
  );

  modport slave (
    input  si, si_valid, clr, po_ready,
    output po, po_valid, overrun, bit_cnt, par_err
  );

endinterface

// File: rtl/sipo_shift_core.sv
// Shift register with clear and enable; exposes its next value so the
// completion edge can capture the word including the bit being accepted.
module sipo_shift_core #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             si,
  output logic [WIDTH-1:0] shr_d_c
);

  logic [WIDTH-1:0] shr_q;

  always_comb begin
    shr_d_c = shr_q;
    if (clr) begin
      shr_d_c = '0;
    end else if (en) begin
      if (MSB_FIRST) shr_d_c = {shr_q[WIDTH-2:0], si};
      else           shr_d_c = {si, shr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) shr_q <= '0;
    else     shr_q <= shr_d_c;
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with word framing, valid/ready output
// and sticky overrun. Define SIPO_DESER_PARITY_EN to append an even-parity bit.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic         clk,
  input logic         rst,
  sipo_deser_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shr_d_c;
  logic             shift_en_c;
  logic             complete_c;
  logic [WIDTH-1:0] po_q;
  logic             po_valid_q;
  logic             overrun_q;
`ifdef SIPO_DESER_PARITY_EN
  logic             perr_c;
  logic             par_err_q;
`endif

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.clr),
    .en      (shift_en_c),
    .si      (bus.si),
    .shr_d_c (shr_d_c)
  );

  // Framing FSM: counts accepted bits and flags the word-completion edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_en_c = 1'b0;
    complete_c = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
    perr_c     = 1'b0;
`endif
    if (bus.clr) begin
      state_d = COLLECT;
      cnt_d   = '0;
    end else if (bus.si_valid) begin
      case (state_q)
        COLLECT: begin
          shift_en_c = 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_DESER_PARITY_EN
            state_d = PARITY;
            cnt_d   = CNT_W'(WIDTH);
`else
            complete_c = 1'b1;
            cnt_d      = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef SIPO_DESER_PARITY_EN
        // Shift is held here, so shr_d_c is the completed data word.
        PARITY: begin
          complete_c = 1'b1;
          cnt_d      = '0;
          state_d    = COLLECT;
          perr_c     = even_par(PAR_MAX_W'(shr_d_c)) ^ bus.si;
        end
`endif
        default: state_d = COLLECT;
      endcase
    end
  end

  // Output word register: load when free or being consumed, else drop and flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bus.clr) overrun_q <= 1'b0;
      if (complete_c) begin
        if (!po_valid_q || bus.po_ready) begin
          po_q       <= shr_d_c;
          po_valid_q <= 1'b1;
`ifdef SIPO_DESER_PARITY_EN
          par_err_q  <= perr_c;
`endif
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (po_valid_q && bus.po_ready) begin
        po_valid_q <= 1'b0;
      end
    end
  end

  assign bus.po       = po_q;
  assign bus.po_valid = po_valid_q;
  assign bus.overrun  = overrun_q;
  assign bus.bit_cnt  = cnt_q;
`ifdef SIPO_DESER_PARITY_EN
  assign bus.par_err  = par_err_q;
`else
  assign bus.par_err  = 1'b0;
`endif

endmodule
